// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+2 cycles from start to done; MTHI/MTLO write in one edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     a_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q, sa_q, div_q, div0_q, done_q;

  // Operand capture: signed ops are reduced to magnitudes plus sign flags.
  logic             go, sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign go     = (state_q == IDLE) && start && !op[2];
  assign sign_a = !op[0] && rs_val[WIDTH-1];
  assign sign_b = !op[0] && rt_val[WIDTH-1];
  assign abs_a  = sign_a ? -rs_val : rs_val;
  assign abs_b  = sign_b ? -rt_val : rt_val;

  // Multiply step: add multiplicand into upper half when LSB set, then shift right.
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_nxt;
  assign madd    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nxt = {madd, acc_q[WIDTH-1:1]};

  // Restoring divide step: remainder in upper half, dividend shifts out as quotient shifts in.
  logic [WIDTH:0]     shl, dif;
  logic [2*WIDTH-1:0] div_nxt;
  assign shl     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign dif     = shl - {1'b0, a_q};
  assign div_nxt = dif[WIDTH] ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  assign prod   = neg_q ? -acc_q : acc_q;
  assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign res_lo = div_q ? (div0_q ? '1 : quo) : prod[WIDTH-1:0];
  assign res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      div_q  <= 1'b0;
      div0_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (go) begin
            a_q    <= op[1] ? abs_b : abs_a;
            acc_q  <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            neg_q  <= sign_a ^ sign_b;
            sa_q   <= sign_a;
            div_q  <= op[1];
            div0_q <= op[1] && (rt_val == '0);
            cnt_q  <= '0;
          end else if (start && op == OP_MTHI) begin
            hi_q <= rs_val;
          end else if (start && op == OP_MTLO) begin
            lo_q <= rs_val;
          end
        end
        RUN: begin
          acc_q <= div_q ? div_nxt : mul_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file and consumes its two read outputs as the rs/rt operands for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It uses a start/busy/done handshake so that the pipeline control can stall on MFHI/MFLO while an operation is in flight.

Parameters:
WIDTH, 32, operand width. Iteration count equals WIDTH. Total latency is WIDTH+2 cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle (busy=0)
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
rs_val  input  WIDTH  operand A / dividend / MTHI-MTLO data (register file read port 1)
rt_val  input  WIDTH  operand B / divisor (register file read port 2)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; new HI/LO are valid in this cycle
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Iteration counter and working registers are cleared.
  - rst has priority over every other input.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, sampled in cycle T:
  - Latch operands. Signed ops latch absolute values plus sign flags; |0x80000000| is treated as unsigned 0x80000000.
  - Clear the counter and go to RUN.
  - busy=1 from cycle T+1.
- RUN: one radix-2 step per cycle for WIDTH cycles (T+1..T+WIDTH), then go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract (remainder, quotient).
- FIX (cycle T+WIDTH+1):
  - Sign correction:
    - Signed product is negated if the operand signs differ.
    - Signed quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - At the closing edge: hi/lo are loaded and the state returns to IDLE.
- Cycle T+WIDTH+2: done=1 for exactly one cycle, busy=0, hi/lo show the new result. hi/lo change only at this update.
- Divide by zero (rt_val=0, DIV or DIVU): same latency; hi=rs_val, lo=all ones.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE with start=1:
  - hi (or lo) <= rs_val at the same edge. The other register is unchanged.
  - busy stays 0 and done is not pulsed.
- Undefined op with start=1: no effect.
- start while busy=1: ignored entirely, including MTHI/MTLO. Operands and result are unaffected.
- start in the same cycle done=1 (state IDLE): accepted normally (back-to-back operations).
- Operand inputs may change freely after the start cycle; only the latched copies are used.
- Reset mid-operation: result discarded, hi=lo=0, busy=0, no done pulse follows.

Test Plan:
- Unsigned multiply: MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start at T → busy T+1..T+33; done at T+34 only; hi=0xFFFFFFFE, lo=0x00000001.
- Signed multiply: MULT rs=-3, rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed divide:
  - DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIVU rs=25, rt=0 → done at T+34, hi=25, lo=0xFFFFFFFF.
- Busy rejection and back-to-back:
  - MULTU 6×7 (hi=0, lo=42); a start with DIVU 9/0 at T+5 is ignored and hi/lo stay 0/42.
  - A new MULTU 2×3 issued in the done cycle → done 34 cycles later, lo=6.
- MTHI/MTLO and reset:
  - MTHI rs=0x1234 in idle → hi=0x1234 next cycle, lo unchanged, busy and done stay 0.
  - Start MULT 5×5, assert rst at T+10 → busy=0, hi=lo=0, and no done pulse for 40 cycles.
